// File: rtl/id_stage_sb_if.sv
// ---------------------------------------------------------------------------
// id_stage_sb_if
// Bundles every non-clock/non-reset signal of the decode stage.
//   IF side : pc_in, inst_in, in_valid, in_ready (from stage), flush
//   WB side : wb_en_in, wb_dest, wb_value
//   EX side : out_valid, out_ready (from EX), pc_out, wb_en, mem_read,
//             mem_write, br, exe_cmd, reg1, reg2, st_val, out_dest
// Modports:
//   slave  - the decode stage itself
//   master - the surrounding pipeline (IF/WB/EX or a testbench)
// ---------------------------------------------------------------------------
interface id_stage_sb_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    logic [DATA_W-1:0] pc_in;
    logic [31:0]       inst_in;
    logic              in_valid;
    logic              in_ready;
    logic              flush;

    logic              wb_en_in;
    logic [AW-1:0]     wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] pc_out;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        br;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] st_val;
    logic [AW-1:0]     out_dest;

    modport slave (
        input  pc_in, inst_in, in_valid, flush,
        input  wb_en_in, wb_dest, wb_value,
        input  out_ready,
        output in_ready, out_valid, pc_out, wb_en, mem_read, mem_write,
        output br, exe_cmd, reg1, reg2, st_val, out_dest
    );

    modport master (
        output pc_in, inst_in, in_valid, flush,
        output wb_en_in, wb_dest, wb_value,
        output out_ready,
        input  in_ready, out_valid, pc_out, wb_en, mem_read, mem_write,
        input  br, exe_cmd, reg1, reg2, st_val, out_dest
    );
endinterface

// File: rtl/id_stage_sb.sv
// ---------------------------------------------------------------------------
// id_stage_sb
// Decode stage with field split, control decode, internal register file,
// per-register in-flight writer scoreboard (RAW / counter-full stalls) and a
// registered ID/EX output with a valid/ready handshake.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - id_stage_sb_if.slave (IF, WB and EX side signals)
//
// Instruction fields: [31:26] op, [25:21] src1, [20:16] src2, [15:11] dest,
// [15:0] imm. Register fields use their low AW bits (AW <= 5).
//
// Control decode (op : exe_cmd, controls):
//   1 ADD:0  3 SUB:2  5 AND:4  6 OR:5  7 NOR:6  8 XOR:7
//   9 SLA:8  10 SLL:8 11 SRA:9 12 SRL:A          (wb_en)
//   32 ADDI:0 33 SUBI:2                           (wb_en, imm)
//   36 LD:0 (wb_en, mem_read, imm)  37 ST:0 (mem_write, imm)
//   40 BEZ br=1, 41 BNE br=2, 42 JMP br=3         (imm)
//   anything else decodes as a NOP (all controls 0).
//
// Optional feature: define ID_WB_BYPASS_EN to let a dependent instruction
// issue in the same cycle as the writeback that resolves it, reading the
// writeback value directly.
// ---------------------------------------------------------------------------
module id_stage_sb #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_sb_if.slave bus
);
    localparam int AW = $clog2(REG_NUM);
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic [1:0]        br;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] st_val;
        logic [AW-1:0]     dest;
    } id_ex_t;

    id_ex_t            idex_q, idex_d;
    logic              valid_q, valid_d;
    logic [SB_CNT_W-1:0] cnt_q [REG_NUM];
    logic [SB_CNT_W-1:0] cnt_d [REG_NUM];
    logic [DATA_W-1:0] rf_q [REG_NUM];
    logic [DATA_W-1:0] rf_d [REG_NUM];

    logic [5:0]        op;
    logic [AW-1:0]     src1, src2, dest, dest_sel;
    logic [15:0]       imm;
    logic              cu_wb_en, cu_mem_read, cu_mem_write, is_imm;
    logic [1:0]        cu_br;
    logic [3:0]        cu_exe_cmd;
    logic              src2_used, src1_pend, src2_pend, dest_full, hazard;
    logic              accept, wb_dec, sb_inc;
    logic [DATA_W-1:0] src1_val, src2_val, imm_sext;

    assign op       = bus.inst_in[31:26];
    assign src1     = bus.inst_in[21 +: AW];
    assign src2     = bus.inst_in[16 +: AW];
    assign dest     = bus.inst_in[11 +: AW];
    assign imm      = bus.inst_in[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};

    // Control unit: unknown opcodes fall through to an all-zero NOP.
    always_comb begin
        cu_wb_en     = 1'b0;
        cu_mem_read  = 1'b0;
        cu_mem_write = 1'b0;
        cu_br        = 2'd0;
        cu_exe_cmd   = 4'h0;
        is_imm       = 1'b0;
        case (op)
            6'd1:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h0; end
            6'd3:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h2; end
            6'd5:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h4; end
            6'd6:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h5; end
            6'd7:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h6; end
            6'd8:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h7; end
            6'd9:  begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h8; end
            6'd10: begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h8; end
            6'd11: begin cu_wb_en = 1'b1; cu_exe_cmd = 4'h9; end
            6'd12: begin cu_wb_en = 1'b1; cu_exe_cmd = 4'hA; end
            6'd32: begin cu_wb_en = 1'b1; is_imm = 1'b1; cu_exe_cmd = 4'h0; end
            6'd33: begin cu_wb_en = 1'b1; is_imm = 1'b1; cu_exe_cmd = 4'h2; end
            6'd36: begin cu_wb_en = 1'b1; cu_mem_read = 1'b1; is_imm = 1'b1; end
            6'd37: begin cu_mem_write = 1'b1; is_imm = 1'b1; end
            6'd40: begin cu_br = 2'd1; is_imm = 1'b1; end
            6'd41: begin cu_br = 2'd2; is_imm = 1'b1; end
            6'd42: begin cu_br = 2'd3; is_imm = 1'b1; end
            default: ;
        endcase
    end

    assign dest_sel  = is_imm ? src2 : dest;
    // Stores and branches read src2 even though they carry an immediate.
    assign src2_used = !is_imm || cu_mem_write || (cu_br != 2'd0);
    assign wb_dec    = bus.wb_en_in && (bus.wb_dest != '0);

    // Register 0 is never counted, so cnt_q[0] stays 0 and rf_q[0] stays 0.
`ifdef ID_WB_BYPASS_EN
    logic src1_wb_hit, src2_wb_hit;
    assign src1_wb_hit = wb_dec && (bus.wb_dest == src1);
    assign src2_wb_hit = wb_dec && (bus.wb_dest == src2);
    // The last outstanding writer retiring this cycle no longer blocks the read.
    assign src1_pend = (cnt_q[src1] != '0) && !(src1_wb_hit && cnt_q[src1] == CNT_ONE);
    assign src2_pend = (cnt_q[src2] != '0) && !(src2_wb_hit && cnt_q[src2] == CNT_ONE);
    assign src1_val  = src1_wb_hit ? bus.wb_value : rf_q[src1];
    assign src2_val  = src2_wb_hit ? bus.wb_value : rf_q[src2];
`else
    assign src1_pend = (cnt_q[src1] != '0);
    assign src2_pend = (cnt_q[src2] != '0);
    assign src1_val  = rf_q[src1];
    assign src2_val  = rf_q[src2];
`endif

    // A new writer cannot issue once its destination counter is saturated.
    assign dest_full = cu_wb_en && (dest_sel != '0) && (cnt_q[dest_sel] == CNT_MAX);
    assign hazard    = src1_pend || (src2_used && src2_pend) || dest_full;
    assign bus.in_ready = !bus.flush && !hazard && (!valid_q || bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign sb_inc    = accept && cu_wb_en && (dest_sel != '0);

    // Scoreboard: issue counts up, writeback counts down, both cancel out.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < REG_NUM; r++) begin
            if (sb_inc && dest_sel == AW'(r)) begin
                if (!(wb_dec && bus.wb_dest == AW'(r)))
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wb_dec && bus.wb_dest == AW'(r) && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_dec)
            rf_d[bus.wb_dest] = bus.wb_value;
    end

    // ID/EX register: load on accept, otherwise only the valid bit drains.
    always_comb begin
        idex_d  = idex_q;
        valid_d = valid_q;
        if (accept) begin
            valid_d          = 1'b1;
            idex_d.pc        = bus.pc_in;
            idex_d.wb_en     = cu_wb_en;
            idex_d.mem_read  = cu_mem_read;
            idex_d.mem_write = cu_mem_write;
            idex_d.br        = cu_br;
            idex_d.exe_cmd   = cu_exe_cmd;
            idex_d.reg1      = src1_val;
            idex_d.reg2      = is_imm ? imm_sext : src2_val;
            idex_d.st_val    = src2_val;
            idex_d.dest      = dest_sel;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
            cnt_q   <= '{default: '0};
            rf_q    <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
            cnt_q   <= cnt_d;
            rf_q    <= rf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.pc_out    = idex_q.pc;
    assign bus.wb_en     = idex_q.wb_en;
    assign bus.mem_read  = idex_q.mem_read;
    assign bus.mem_write = idex_q.mem_write;
    assign bus.br        = idex_q.br;
    assign bus.exe_cmd   = idex_q.exe_cmd;
    assign bus.reg1      = idex_q.reg1;
    assign bus.reg2      = idex_q.reg2;
    assign bus.st_val    = idex_q.st_val;
    assign bus.out_dest  = idex_q.dest;
endmodule

// File: tb/tb_id_stage_sb.sv
// ---------------------------------------------------------------------------
// tb_id_stage_sb
// Self-checking bench for id_stage_sb. A driver issues one cycle of stimulus
// at a time and keeps a behavioural model (pending-writer counts, register
// values, ID/EX occupancy); every accepted instruction pushes its expected
// ID/EX contents into a queue that a separate monitor pops on handshakes.
// Build with +define+ID_WB_BYPASS_EN to exercise the bypass variant.
// ---------------------------------------------------------------------------
module tb_id_stage_sb;
    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;
    localparam int AW      = 5;
    localparam int CNT_MAX = 3;
`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        bit          wb, mr, mw;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [31:0] r1, r2, sv;
        logic [4:0]  dest;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_sb_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    id_stage_sb #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .SB_CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          pend [REG_NUM];
    logic [31:0] rf   [REG_NUM];
    bit          ov;
    int          wbq [$];
    pkt_t        expq [$];
    int          checks = 0;
    int          passed = 0;
    bit          dutReady, lastAccept;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference control table, written per instruction mnemonic.
    function automatic void ctrl(input logic [5:0] op, output bit wb, output bit mr, output bit mw,
                                 output bit imm, output logic [1:0] br, output logic [3:0] cmd);
        wb = 0; mr = 0; mw = 0; imm = 0; br = 2'd0; cmd = 4'h0;
        case (op)
            6'd1:  wb = 1;                           // ADD
            6'd3:  begin wb = 1; cmd = 4'h2; end     // SUB
            6'd5:  begin wb = 1; cmd = 4'h4; end     // AND
            6'd6:  begin wb = 1; cmd = 4'h5; end     // OR
            6'd7:  begin wb = 1; cmd = 4'h6; end     // NOR
            6'd8:  begin wb = 1; cmd = 4'h7; end     // XOR
            6'd9, 6'd10: begin wb = 1; cmd = 4'h8; end // SLA/SLL
            6'd11: begin wb = 1; cmd = 4'h9; end     // SRA
            6'd12: begin wb = 1; cmd = 4'hA; end     // SRL
            6'd32: begin wb = 1; imm = 1; end        // ADDI
            6'd33: begin wb = 1; imm = 1; cmd = 4'h2; end // SUBI
            6'd36: begin wb = 1; mr = 1; imm = 1; end // LD
            6'd37: begin mw = 1; imm = 1; end        // ST
            6'd40: begin br = 2'd1; imm = 1; end     // BEZ
            6'd41: begin br = 2'd2; imm = 1; end     // BNE
            6'd42: begin br = 2'd3; imm = 1; end     // JMP
            default: ;
        endcase
    endfunction

    // Outstanding writers still blocking a read of r this cycle.
    function automatic int livePend(input logic [4:0] r, input bit wbe, input logic [4:0] wbd);
        int p = pend[r];
        if (BYP && wbe && wbd == r && p > 0) p--;
        return p;
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] r, input bit wbe, input logic [4:0] wbd,
                                            input logic [31:0] wbv);
        if (r == 5'd0) return 32'h0;
        if (BYP && wbe && wbd == r) return wbv;
        return rf[r];
    endfunction

    function automatic logic [31:0] rtype(input int op, input int s1, input int s2, input int d);
        return {op[5:0], s1[4:0], s2[4:0], d[4:0], 11'h0};
    endfunction

    function automatic logic [31:0] itype(input int op, input int s1, input int s2, input logic [15:0] im);
        return {op[5:0], s1[4:0], s2[4:0], im};
    endfunction

    task automatic modelReset();
        foreach (pend[i]) begin pend[i] = 0; rf[i] = 32'h0; end
        ov = 0;
        wbq.delete();
        expq.delete();
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic applyStimulus(input bit iv, input logic [31:0] inst, input bit fl, input bit ordy,
                                 input bit wbe, input logic [4:0] wbd, input logic [31:0] wbv);
        logic [4:0]  s1, s2, d, dsel;
        logic [15:0] im;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [31:0] pc;
        bit          wb, mr, mw, isImm, use2, hz, expReady;
        pkt_t        p;
        pc = $urandom;
        @(negedge clk);
        bus.in_valid = iv; bus.inst_in = inst; bus.pc_in = pc; bus.flush = fl;
        bus.out_ready = ordy; bus.wb_en_in = wbe; bus.wb_dest = wbd; bus.wb_value = wbv;
        #1;
        s1 = inst[25:21]; s2 = inst[20:16]; d = inst[15:11]; im = inst[15:0];
        ctrl(inst[31:26], wb, mr, mw, isImm, br, cmd);
        dsel = isImm ? s2 : d;
        use2 = !isImm || mw || (br != 2'd0);
        hz = (livePend(s1, wbe, wbd) > 0) || (use2 && livePend(s2, wbe, wbd) > 0)
             || (wb && dsel != 5'd0 && pend[dsel] >= CNT_MAX);
        expReady = !fl && !hz && (!ov || ordy);
        dutReady = bus.in_ready;
        checkOutput("out_valid", {63'h0, bus.out_valid}, {63'h0, ov});
        checkOutput("in_ready", {63'h0, bus.in_ready}, {63'h0, expReady});
        lastAccept = iv && expReady;
        if (lastAccept) begin
            p.pc = pc; p.wb = wb; p.mr = mr; p.mw = mw; p.br = br; p.cmd = cmd;
            p.r1 = readReg(s1, wbe, wbd, wbv);
            p.sv = readReg(s2, wbe, wbd, wbv);
            p.r2 = isImm ? {{16{im[15]}}, im} : p.sv;
            p.dest = dsel;
            expq.push_back(p);
            if (wb && dsel != 5'd0) begin pend[dsel]++; wbq.push_back(int'(dsel)); end
        end
        if (wbe && wbd != 5'd0) begin
            if (pend[wbd] > 0) pend[wbd]--;
            rf[wbd] = wbv;
            for (int i = 0; i < wbq.size(); i++)
                if (wbq[i] == int'(wbd)) begin wbq.delete(i); break; end
        end
        if (lastAccept) ov = 1;
        else if (ordy) ov = 0;
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(0, 32'h0, 0, ordy, 0, 5'd0, 32'h0);
    endtask

    // Retire every outstanding writer and empty the ID/EX register.
    task automatic drainWb();
        for (int k = 0; k < 64 && (wbq.size() > 0 || ov); k++) begin
            if (wbq.size() > 0) applyStimulus(0, 32'h0, 0, 1, 1, 5'(wbq[0]), $urandom);
            else idle(1);
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, {63'h0, bus.out_valid}, 64'h0);
        checkOutput({tag, "_pc_out"}, {32'h0, bus.pc_out}, 64'h0);
        checkOutput({tag, "_reg1"}, {32'h0, bus.reg1}, 64'h0);
        checkOutput({tag, "_reg2"}, {32'h0, bus.reg2}, 64'h0);
        checkOutput({tag, "_st_val"}, {32'h0, bus.st_val}, 64'h0);
        checkOutput({tag, "_dest_ctrl"}, {50'h0, bus.out_dest, bus.wb_en, bus.mem_read,
                    bus.mem_write, bus.br, bus.exe_cmd}, 64'h0);
    endtask

    // Monitor: compares the ID/EX contents whenever EX takes them.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checkOutput("expq_nonempty", {63'h0, expq.size() != 0}, 64'h1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checkOutput("pc_out", {32'h0, bus.pc_out}, {32'h0, e.pc});
                    checkOutput("ctrl", {57'h0, bus.wb_en, bus.mem_read, bus.mem_write, bus.br,
                                bus.exe_cmd[1:0]}, {57'h0, e.wb, e.mr, e.mw, e.br, e.cmd[1:0]});
                    checkOutput("exe_cmd", {60'h0, bus.exe_cmd}, {60'h0, e.cmd});
                    checkOutput("reg1", {32'h0, bus.reg1}, {32'h0, e.r1});
                    checkOutput("reg2", {32'h0, bus.reg2}, {32'h0, e.r2});
                    checkOutput("st_val", {32'h0, bus.st_val}, {32'h0, e.sv});
                    checkOutput("out_dest", {59'h0, bus.out_dest}, {59'h0, e.dest});
                end
            end
        end
    end

    initial begin
        logic [5:0] opTab [19];
        logic [31:0] inst;
        logic [4:0] wbd;
        bit wbe;
        opTab = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
                  6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd63};

        // Reset state
        bus.in_valid = 0; bus.inst_in = 0; bus.pc_in = 0; bus.flush = 0;
        bus.out_ready = 0; bus.wb_en_in = 0; bus.wb_dest = 0; bus.wb_value = 0;
        rst = 1'b0;
        modelReset();
        @(negedge clk); @(negedge clk);
        #1;
        checkZeroOutputs("reset");
        rst = 1'b1;

        // Preload r1/r2 with writebacks that have no pending writer.
        applyStimulus(0, 32'h0, 0, 1, 1, 5'd1, 32'h11);
        applyStimulus(0, 32'h0, 0, 1, 1, 5'd2, 32'h22);

        // ADDI r7,r0,-1 held in ID/EX for three cycles, then drained.
        applyStimulus(1, itype(32, 0, 7, 16'hFFFF), 0, 0, 0, 5'd0, 32'h0);
        idle(0);
        checkOutput("addi_reg2", {32'h0, bus.reg2}, 64'hFFFF_FFFF);
        checkOutput("addi_dest", {59'h0, bus.out_dest}, 64'd7);
        checkOutput("addi_st_val", {32'h0, bus.st_val}, 64'h0);
        idle(0);
        applyStimulus(1, rtype(1, 1, 2, 10), 0, 0, 0, 5'd0, 32'h0);
        checkOutput("hold_in_ready", {63'h0, dutReady}, 64'h0);
        checkOutput("hold_reg2", {32'h0, bus.reg2}, 64'hFFFF_FFFF);
        checkOutput("hold_dest", {59'h0, bus.out_dest}, 64'd7);
        applyStimulus(1, rtype(1, 1, 2, 10), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("drain_accept", {63'h0, dutReady}, 64'h1);
        drainWb();

        // RAW: ADD r3,r1,r2 then ADD r4,r3,r0.
        applyStimulus(1, rtype(1, 1, 2, 3), 0, 1, 0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, rtype(1, 3, 0, 4), 0, 1, 0, 5'd0, 32'h0);
            checkOutput("raw_stall", {63'h0, dutReady}, 64'h0);
        end
        applyStimulus(1, rtype(1, 3, 0, 4), 0, 1, 1, 5'd3, 32'h1234);
        checkOutput("raw_wb_cycle", {63'h0, dutReady}, {63'h0, BYP});
        if (!lastAccept) begin
            applyStimulus(1, rtype(1, 3, 0, 4), 0, 1, 0, 5'd0, 32'h0);
            checkOutput("raw_after_wb", {63'h0, dutReady}, 64'h1);
        end
        idle(1);
        checkOutput("raw_reg1", {32'h0, bus.reg1}, 64'h1234);
        checkOutput("raw_dest", {59'h0, bus.out_dest}, 64'd4);
        drainWb();

        // Counter saturation on r9.
        for (int k = 0; k < 3; k++)
            applyStimulus(1, itype(32, 0, 9, 16'(k)), 0, 1, 0, 5'd0, 32'h0);
        applyStimulus(1, itype(32, 0, 9, 16'h3), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("sat_4th_stall", {63'h0, dutReady}, 64'h0);
        applyStimulus(1, itype(32, 0, 9, 16'h3), 0, 1, 1, 5'd9, 32'h99);
        checkOutput("sat_wb_cycle", {63'h0, dutReady}, 64'h0);
        applyStimulus(1, itype(32, 0, 9, 16'h3), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("sat_issue", {63'h0, dutReady}, 64'h1);
        applyStimulus(1, itype(32, 0, 9, 16'h4), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("sat_full_again", {63'h0, dutReady}, 64'h0);
        drainWb();

        // Flush with a held ID/EX entry.
        applyStimulus(1, itype(32, 0, 11, 16'h5), 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(1, itype(32, 0, 12, 16'h6), 1, 0, 0, 5'd0, 32'h0);
        checkOutput("flush_in_ready", {63'h0, dutReady}, 64'h0);
        idle(0);
        checkOutput("flush_idex_hold", {59'h0, bus.out_dest}, 64'd11);
        applyStimulus(1, rtype(1, 12, 12, 13), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("flush_no_score", {63'h0, dutReady}, 64'h1);
        drainWb();

        // Asynchronous reset with out_valid=1 and two writers to r5.
        applyStimulus(1, itype(32, 0, 5, 16'h1), 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(1, itype(32, 0, 5, 16'h2), 0, 1, 0, 5'd0, 32'h0);
        idle(0);
        #2;
        bus.in_valid = 0; bus.wb_en_in = 0; bus.flush = 0;
        rst = 1'b0;
        #1;
        checkZeroOutputs("midrst");
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, rtype(1, 5, 0, 6), 0, 1, 0, 5'd0, 32'h0);
        checkOutput("midrst_r5_free", {63'h0, dutReady}, 64'h1);
        drainWb();

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            inst = {opTab[$urandom_range(0, 18)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 11'($urandom)};
            wbe = 0; wbd = 5'd0;
            if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wbe = 1; wbd = 5'(wbq[$urandom_range(0, wbq.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                wbe = 1;
            end
            applyStimulus($urandom_range(0, 3) != 0, inst, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0, wbe, wbd, $urandom);
        end
        drainWb();
        idle(1);
        checkOutput("final_queue_empty", 64'(expq.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
